// File: rtl/multicycle_controlunit_if.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_controlunit_if
//  Purpose  : Instruction handshake and datapath control bundle between
//             instruction fetch (master) and the multi-cycle control unit
//             (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface multicycle_controlunit_if #(
  parameter int FUNC_W  = 6,
  parameter int ALUOP_W = 4
);
  logic               instr_valid;
  logic               instr_ready;
  logic               insmsb;
  logic [FUNC_W-1:0]  func;
  logic               flush;
  logic               ALUsrc;
  logic [ALUOP_W-1:0] ALUop;
  logic               Immsel;
  logic               regwrite;
  logic               regreset;
  logic               busy;
  logic               done;
  logic               illegal;

  // Fetch side: offers instructions, observes the control outputs
  modport master (
    output instr_valid, insmsb, func, flush,
    input  instr_ready, ALUsrc, ALUop, Immsel, regwrite, regreset,
           busy, done, illegal
  );

  // Control unit side
  modport slave (
    input  instr_valid, insmsb, func, flush,
    output instr_ready, ALUsrc, ALUop, Immsel, regwrite, regreset,
           busy, done, illegal
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_controlunit.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_controlunit
//  Purpose  : Multi-cycle control unit. Accepts one instruction per
//             handshake and sequences it through DECODE, EXEC (1 or
//             EXEC_CYCLES cycles) and WB, holding the decoded ALU controls
//             stable for the whole instruction.
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_controlunit #(
  parameter int FUNC_W      = 6,
  parameter int ALUOP_W     = 4,
  parameter int NUM_ALU_OPS = 13,
  parameter int MC_OP_BASE  = 10,
  parameter int EXEC_CYCLES = 4
) (
  input  wire                      clk,
  input  wire                      rstn,
  multicycle_controlunit_if.slave  bus
);

  localparam int C_CNT_W = $clog2(EXEC_CYCLES + 1);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_IDLE   = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [ALUOP_W-1:0] r_aluop;
  logic               r_insmsb;
  logic [C_CNT_W-1:0] r_cnt;
  logic               w_accept;
  logic               w_illegal_op;
  logic               w_multi_op;

  // Opcode classification is taken from the captured opcode register
  assign w_accept     = (r_state == S_IDLE) && bus.instr_valid && !bus.flush;
  assign w_illegal_op = int'(r_aluop) >= NUM_ALU_OPS;
  assign w_multi_op   = int'(r_aluop) >= MC_OP_BASE;

  // State register; reset forces RST immediately
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_RST;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RST:    w_next = S_IDLE;
      S_IDLE:   if (w_accept) w_next = S_DECODE;
      S_DECODE: begin
        if (bus.flush || w_illegal_op) w_next = S_IDLE;
        else                           w_next = S_EXEC;
      end
      S_EXEC: begin
        if (bus.flush)                 w_next = S_IDLE;
        else if (r_cnt == '0)          w_next = S_WB;
      end
      S_WB:     w_next = S_IDLE;
      default:  w_next = S_RST;
    endcase
  end

  // Instruction capture at acceptance so decoded controls are valid in DECODE
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_aluop  <= '0;
      r_insmsb <= 1'b0;
    end else if (w_accept) begin
      r_aluop  <= bus.func[FUNC_W-1 -: ALUOP_W];
      r_insmsb <= bus.insmsb;
    end
  end

  // EXEC length counter: loaded in DECODE, counts down to zero in EXEC
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (r_state == S_DECODE) begin
      r_cnt <= w_multi_op ? C_CNT_W'(EXEC_CYCLES - 1) : '0;
    end else if ((r_state == S_EXEC) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - C_CNT_W'(1);
    end
  end

  // Outputs decode from registered state; only WB strobes see flush directly
  assign bus.instr_ready = (r_state == S_IDLE);
  assign bus.busy        = (r_state == S_DECODE) || (r_state == S_EXEC) ||
                           (r_state == S_WB);
  assign bus.regwrite    = (r_state == S_WB) && !bus.flush;
  assign bus.done        = (r_state == S_WB) && !bus.flush;
  assign bus.illegal     = (r_state == S_DECODE) && w_illegal_op;
  assign bus.regreset    = (r_state == S_RST);
  assign bus.ALUop       = r_aluop;
  assign bus.ALUsrc      = r_insmsb;
  assign bus.Immsel      = r_insmsb;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controlunit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_controlunit
//  Purpose  : Directed self-checking bench for multicycle_controlunit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_controlunit;

  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_err;

  multicycle_controlunit_if #(.FUNC_W(6), .ALUOP_W(4)) bus ();

  multicycle_controlunit #(
    .FUNC_W(6), .ALUOP_W(4), .NUM_ALU_OPS(13), .MC_OP_BASE(10), .EXEC_CYCLES(4)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {instr_ready, busy, regwrite, done, illegal, regreset}
  function automatic logic [5:0] ctl();
    return {bus.instr_ready, bus.busy, bus.regwrite, bus.done, bus.illegal, bus.regreset};
  endfunction

  // {ALUsrc, Immsel, ALUop}
  function automatic logic [5:0] alu();
    return {bus.ALUsrc, bus.Immsel, bus.ALUop};
  endfunction

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rstn = 1'b0;
    bus.instr_valid = 1'b0;
    bus.insmsb = 1'b0;
    bus.func = '0;
    bus.flush = 1'b0;

    // Reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_ctl", ctl(), 6'b000001);
      chk("rst_alu", alu(), 6'b000000);
    end
    rstn = 1'b1;
    #1 chk("rel_cycle", ctl(), 6'b000001);
    cyc();
    chk("idle_after_rel", ctl(), 6'b100000);
    chk("idle_alu", alu(), 6'b000000);

    // Immediate single-cycle op 0
    bus.instr_valid = 1'b1; bus.insmsb = 1'b1; bus.func = 6'b000000;
    cyc(); bus.instr_valid = 1'b0;
    chk("imm_dec_ctl", ctl(), 6'b010000);
    chk("imm_dec_alu", alu(), 6'b110000);
    cyc();
    chk("imm_exec_ctl", ctl(), 6'b010000);
    cyc();
    chk("imm_wb_ctl", ctl(), 6'b011100);
    chk("imm_wb_alu", alu(), 6'b110000);
    cyc();
    chk("imm_idle_ctl", ctl(), 6'b100000);
    chk("imm_idle_alu", alu(), 6'b110000);

    // Register multi-cycle op 12
    bus.instr_valid = 1'b1; bus.insmsb = 1'b0; bus.func = 6'b110000;
    for (int k = 1; k <= 7; k++) begin
      cyc(); bus.instr_valid = 1'b0;
      if (k <= 5)      chk("reg_busy", ctl(), 6'b010000);
      else if (k == 6) chk("reg_wb", ctl(), 6'b011100);
      else             chk("reg_idle", ctl(), 6'b100000);
      if (k == 1) chk("reg_alu", alu(), 6'b001100);
    end

    // Illegal op 15
    bus.instr_valid = 1'b1; bus.insmsb = 1'b0; bus.func = 6'b111100;
    cyc(); bus.instr_valid = 1'b0;
    chk("ill_pulse", ctl(), 6'b010010);
    cyc();
    chk("ill_ready", ctl(), 6'b100000);
    cyc();
    chk("ill_quiet", ctl(), 6'b100000);

    // Flush during the 2nd EXEC cycle of op 12
    bus.instr_valid = 1'b1; bus.insmsb = 1'b1; bus.func = 6'b110011;
    cyc(); bus.instr_valid = 1'b0;
    chk("fl_dec", ctl(), 6'b010000);
    cyc();
    chk("fl_exec1", ctl(), 6'b010000);
    cyc();
    chk("fl_exec2", ctl(), 6'b010000);
    bus.flush = 1'b1;
    cyc(); bus.flush = 1'b0;
    chk("fl_idle", ctl(), 6'b100000);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("fl_no_wb", ctl(), 6'b100000);
    end

    // flush with instr_valid in IDLE: no capture
    bus.instr_valid = 1'b1; bus.flush = 1'b1; bus.insmsb = 1'b0; bus.func = 6'b000100;
    cyc(); bus.instr_valid = 1'b0; bus.flush = 1'b0;
    chk("fl_nocap_ctl", ctl(), 6'b100000);
    chk("fl_nocap_alu", alu(), 6'b111100);

    // flush in WB gates regwrite/done combinationally
    bus.instr_valid = 1'b1; bus.insmsb = 1'b0; bus.func = 6'b001000;
    cyc(); bus.instr_valid = 1'b0;
    cyc();
    cyc();
    chk("wbfl_pre", ctl(), 6'b011100);
    bus.flush = 1'b1;
    #1 chk("wbfl_gated", ctl(), 6'b010000);
    cyc(); bus.flush = 1'b0;
    chk("wbfl_idle", ctl(), 6'b100000);

    // Reset mid-instruction while in EXEC
    bus.instr_valid = 1'b1; bus.insmsb = 1'b1; bus.func = 6'b110000;
    cyc(); bus.instr_valid = 1'b0;
    cyc();
    chk("mr_exec", ctl(), 6'b010000);
    #2 rstn = 1'b0;
    #1 chk("mr_ctl", ctl(), 6'b000001);
    chk("mr_alu", alu(), 6'b000000);
    cyc();
    rstn = 1'b1;
    cyc();
    chk("mr_idle", ctl(), 6'b100000);

    // Back-to-back single-cycle ops: op 1 then op 2, valid held high
    bus.instr_valid = 1'b1; bus.insmsb = 1'b0; bus.func = 6'b000100;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (k == 1) bus.func = 6'b001000;
      if (k == 5) bus.instr_valid = 1'b0;
      case (k)
        3, 7:    chk("b2b_wb", ctl(), 6'b011100);
        4:       chk("b2b_idle", ctl(), 6'b100000);
        8:       chk("b2b_end", ctl(), 6'b100000);
        default: chk("b2b_busy", ctl(), 6'b010000);
      endcase
      if (k == 1) chk("b2b_alu1", alu(), 6'b000001);
      if (k == 5) chk("b2b_alu2", alu(), 6'b000010);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_controlunit.md
# multicycle_controlunit

Parametrised multi-cycle successor to the single-cycle `controlunit`. It accepts one instruction (`insmsb`, `func`) per valid/ready handshake, then sequences it through DECODE, EXECUTE and WRITEBACK states. It holds `ALUsrc`, `ALUop` and `Immsel` stable for the whole instruction. Long ALU operations stretch EXECUTE over a programmable number of cycles. It sits between instruction fetch and the datapath (register file and ALU) of the processor.

## Interface
- `FUNC_W`, 6: width of the `func` field.
- `ALUOP_W`, 4: width of `ALUop`; must satisfy `ALUOP_W <= FUNC_W`.
- `NUM_ALU_OPS`, 13: number of legal ALU opcodes (0 .. `NUM_ALU_OPS`-1).
- `MC_OP_BASE`, 10: opcodes >= this value are multi-cycle.
- `EXEC_CYCLES`, 4: EXECUTE length for multi-cycle ops; must be >= 2.
- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `instr_valid`  in  1  an instruction is offered.
- `instr_ready`  out  1  the block can accept an instruction.
- `insmsb`  in  1  instruction MSB: 1 = immediate form, 0 = register form.
- `func`  in  `FUNC_W`  function field.
- `flush`  in  1  synchronous abort of the current instruction.
- `ALUsrc`  out  1  1 = ALU operand B comes from the immediate.
- `ALUop`  out  `ALUOP_W`  ALU operation.
- `Immsel`  out  1  immediate generator enable.
- `regwrite`  out  1  register-file write strobe.
- `regreset`  out  1  register-file clear.
- `busy`  out  1  an instruction is in flight.
- `done`  out  1  one-cycle pulse when an instruction retires.
- `illegal`  out  1  one-cycle pulse when an opcode is rejected.

## Operation
- States: RST, IDLE, DECODE, EXEC, WB.
- Reset (`rstn` low): the block is forced to RST immediately.
  - Outputs during reset: `regreset`=1; all other outputs 0, including `instr_ready`=0.
- Reset deassertion:
  - The first clock edge with `rstn` high moves RST to IDLE.
  - `regreset` is therefore asserted for exactly one cycle after release.
- IDLE:
  - `instr_ready`=1.
  - When `instr_valid` & `instr_ready` & !`flush`: capture `insmsb` and `func`, then go to DECODE.
- Opcode:
  - `op` = `func[FUNC_W-1 -: ALUOP_W]`; the low `FUNC_W-ALUOP_W` bits are ignored.
- DECODE, one cycle:
  - If `op` >= `NUM_ALU_OPS`: pulse `illegal`, return to IDLE. No `regwrite`, no `done`.
  - Otherwise go to EXEC and load the EXEC cycle counter.
- Decoded outputs: `ALUop`=`op`, `ALUsrc`=`insmsb`, `Immsel`=`insmsb`.
  - Registered; valid from the DECODE cycle through the WB cycle.
  - Held at their last value in IDLE.
  - Cleared only by reset.
- EXEC:
  - Lasts 1 cycle if `op` < `MC_OP_BASE`, otherwise `EXEC_CYCLES` cycles.
  - The counter width is `$clog2(EXEC_CYCLES+1)`.
- WB, one cycle: `regwrite`=1 and `done`=1, then go to IDLE.
- `busy`=1 in DECODE, EXEC and WB.
- `flush`:
  - In DECODE, EXEC or WB, `flush` moves the block to IDLE on the next edge.
  - A flushed instruction never produces `regwrite`, `done` or `illegal` after the flush cycle.
  - `flush` asserted in the WB cycle itself suppresses that cycle's `regwrite` and `done` combinationally.
- `instr_valid` outside IDLE is ignored; the offering side must hold it until accepted.

## Timing
- Acceptance edge is N. Then DECODE = N+1, EXEC = N+2, WB = N+3 (single-cycle op), IDLE = N+4.
- Multi-cycle op: WB = N+2+`EXEC_CYCLES`.
- Throughput: one single-cycle instruction per 4 cycles. Back-to-back acceptance is legal in the IDLE cycle that follows WB.
- Illegal op: `illegal` is high in cycle N+1; `instr_ready` is high again in N+2.
- `instr_ready`, `busy`, `regwrite`, `done` and `illegal` decode from registered state only. The exception is the WB `flush` gating.
- Reset mid-instruction: all outputs drop to their reset values asynchronously. The instruction is lost. No `regwrite` occurs.

## Test plan
- **Reset release.** Hold `rstn`=0 for 3 cycles, then release.
  - Required: `regreset`=1 throughout reset and for exactly 1 cycle after release; `instr_ready`=1 on the next cycle.
  - All other outputs 0 throughout.
- **Immediate single-cycle op.** `insmsb`=1, `func`=000000.
  - Required: `ALUsrc`=`Immsel`=1 and `ALUop`=0000 from N+1.
  - Required: `regwrite`=`done`=1 only at N+3.
- **Register op.** `insmsb`=0, `func`=110000.
  - Required: `ALUop`=1100, `ALUsrc`=0.
  - Op 12 >= `MC_OP_BASE`, so EXEC lasts 4 cycles and `regwrite` fires at N+6.
- **Illegal op.** `func`=111100 (op 15 >= 13).
  - Required: `illegal` pulse at N+1, no `regwrite`, `instr_ready`=1 at N+2.
- **Flush.** Assert `flush` during the 2nd EXEC cycle of op 12.
  - Required: IDLE on the next cycle, no `regwrite` or `done`.
  - Also: `flush` together with `instr_valid` in IDLE results in no capture.
- **Mid-instruction reset and back-to-back.** Pull `rstn` low in EXEC.
  - Required: immediate return to reset outputs.
  - Then issue 2 back-to-back single-cycle ops: `done` at N+3 and N+7.
